// File: rtl/io_nto1_chk.sv
// io_nto1_chk: traffic generator and in-order checker harness for N-to-1 merge networks
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
module io_nto1_chk #(
    parameter int NUM_SRC  = 2,
    parameter int SRC_BASE = 0,
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 1,
    parameter int ASZ      = `NS_ADDRESS_SIZE,
    parameter int DSZ      = `NS_DATA_SIZE,
    parameter int RSZ      = `NS_REDUN_SIZE,
    parameter int CSZ      = 4,
    parameter int MSG_CNT  = 0,
    parameter bit CHK_RED  = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_run,
    output logic [NUM_SRC*ASZ-1:0] o_src,
    output logic [NUM_SRC*ASZ-1:0] o_dst,
    output logic [NUM_SRC*DSZ-1:0] o_dat,
    output logic [NUM_SRC*RSZ-1:0] o_red,
    output logic [NUM_SRC-1:0]     o_req,
    input  logic [NUM_SRC-1:0]     o_ack,
    input  logic [ASZ-1:0]         i0_src,
    input  logic [ASZ-1:0]         i0_dst,
    input  logic [DSZ-1:0]         i0_dat,
    input  logic [RSZ-1:0]         i0_red,
    input  logic                   i0_req,
    output logic                   i0_ack,
    output logic [NUM_SRC-1:0]     o_seq_err,
    output logic                   o_src_err,
    output logic                   o_red_err,
    output logic                   o_fst_err_vld,
    output logic [ASZ-1:0]         o_fst_err_src,
    output logic [DSZ-1:0]         o_fst_err_exp,
    output logic [DSZ-1:0]         o_fst_err_got,
    output logic [15:0]            o_rx_total,
    output logic                   o_done
);
    localparam int XW  = ASZ > DSZ ? ASZ : DSZ;
    localparam int W   = XW > RSZ ? XW : RSZ;
    localparam int CW  = ASZ > 32 ? ASZ : 32;
    localparam int IW  = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    localparam int TOT = NUM_SRC * MSG_CNT > 65535 ? 65535 : NUM_SRC * MSG_CNT;
    logic [1:0] rst_q;
    logic       rst_n;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_q <= '0;
        else rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_n = rst_q[1];
    logic [NUM_SRC-1:0] fin;
    genvar k;
    for (k = 0; k < NUM_SRC; k++) begin : g_src
        localparam logic [ASZ-1:0] SID = ASZ'(SRC_BASE + k);
        logic           req;
        logic [CSZ-1:0] seq;
        logic [31:0]    sent;
        logic [ASZ-1:0] src, dst;
        logic [DSZ-1:0] dat;
        logic [RSZ-1:0] red;
        logic [W-1:0]   mix;
        logic           unused_mix;
        assign mix        = W'(SID) ^ W'(seq);
        assign unused_mix = ^mix;
        assign fin[k]     = MSG_CNT != 0 && sent == 32'(MSG_CNT);
        always_ff @(posedge i_clk or negedge rst_n) begin
            if (!rst_n) begin
                req  <= 1'b0;
                seq  <= '0;
                sent <= '0;
                src  <= '0;
                dst  <= ASZ'(MIN_ADDR);
                dat  <= '0;
                red  <= '0;
            end else if (!req) begin
                if (i_run && !o_ack[k] && !fin[k]) begin
                    req <= 1'b1;
                    src <= SID;
                    dat <= DSZ'(seq);
                    red <= CHK_RED ? mix[RSZ-1:0] : '0;
                end
            end else if (o_ack[k]) begin
                req  <= 1'b0;
                seq  <= seq + 1'b1;
                sent <= sent + 1'b1;
                dst  <= dst >= ASZ'(MAX_ADDR) ? ASZ'(MIN_ADDR) : dst + 1'b1;
            end
        end
        assign o_req[k]             = req;
        assign o_src[k*ASZ +: ASZ]  = src;
        assign o_dst[k*ASZ +: ASZ]  = dst;
        assign o_dat[k*DSZ +: DSZ]  = dat;
        assign o_red[k*RSZ +: RSZ]  = red;
    end
    logic                 ack_q;
    logic [2**IW-1:0]     seq_err_q;
    logic [CSZ-1:0]       exp_q [2**IW];
    logic [ASZ-1:0]       idx;
    logic [IW-1:0]        sel;
    logic [CSZ-1:0]       exp_sel;
    logic [DSZ-1:0]       exp_d;
    logic [W-1:0]         rmix;
    logic                 src_bad, seq_bad, red_bad, chk_err;
    assign idx     = i0_src - ASZ'(SRC_BASE);
    assign sel     = idx[IW-1:0];
    assign src_bad = CW'(idx) >= CW'(NUM_SRC);
    assign exp_sel = exp_q[sel];
    assign exp_d   = DSZ'(exp_sel);
    // full-width compare so any data bit above the counter counts as a mismatch
    assign seq_bad = !src_bad && i0_dat != exp_d;
    assign rmix    = W'(i0_src) ^ W'(i0_dat);
    assign red_bad = CHK_RED && i0_red != rmix[RSZ-1:0];
    assign chk_err = src_bad || seq_bad || red_bad;
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q         <= 1'b0;
            seq_err_q     <= '0;
            o_src_err     <= 1'b0;
            o_red_err     <= 1'b0;
            o_fst_err_vld <= 1'b0;
            o_fst_err_src <= '0;
            o_fst_err_exp <= '0;
            o_fst_err_got <= '0;
            o_rx_total    <= '0;
            for (int i = 0; i < 2**IW; i++) exp_q[i] <= '0;
        end else if (i0_req && !ack_q) begin
            ack_q <= 1'b1;
            if (src_bad) o_src_err <= 1'b1;
            else begin
                exp_q[sel] <= seq_bad ? i0_dat[CSZ-1:0] + 1'b1 : exp_sel + 1'b1;
                if (seq_bad) seq_err_q[sel] <= 1'b1;
            end
            if (red_bad) o_red_err <= 1'b1;
            if (chk_err && !o_fst_err_vld) begin
                o_fst_err_vld <= 1'b1;
                o_fst_err_src <= i0_src;
                o_fst_err_exp <= src_bad ? '0 : exp_d;
                o_fst_err_got <= i0_dat;
            end
            if (o_rx_total != 16'hFFFF) o_rx_total <= o_rx_total + 1'b1;
        end else if (!i0_req && ack_q) begin
            ack_q <= 1'b0;
        end
    end
    assign i0_ack    = ack_q;
    assign o_seq_err = seq_err_q[NUM_SRC-1:0];
    assign o_done    = MSG_CNT != 0 && &fin && o_rx_total == 16'(TOT);
    logic unused_ok;
    assign unused_ok = ^{i0_dst, rmix, seq_err_q};
endmodule

// File: doc/io_nto1_chk.md
Name: io_nto1_chk

Overview:
- Parametrised traffic-generator and checker harness for N-to-1 merge networks.
- Drives NUM_SRC independent four-phase source channels into the design under test and consumes its single output channel.
- The sink checks per-source sequence order, source-id range and redundancy field.
- Captures the first error for on-board debug and signals completion after a programmable message count.

Parameters:
NUM_SRC, 2, number of source channels (1..8)
SRC_BASE, 0, src id of channel 0; channel k sends src = SRC_BASE+k
MIN_ADDR, 1, lowest destination address cycled by sources
MAX_ADDR, 1, highest destination address cycled by sources
ASZ, `NS_ADDRESS_SIZE, address field width
DSZ, `NS_DATA_SIZE, data field width
RSZ, `NS_REDUN_SIZE, redundancy field width
CSZ, 4, sequence counter width (CSZ <= DSZ)
MSG_CNT, 0, messages per source before stopping; 0 = run forever
CHK_RED, 0, 1 = sources fill red and the sink checks it; 0 = red driven 0 and not checked

Ports:
i_clk  input  1  main clock
i_rst_n  input  1  asynchronous active-low reset
i_run  input  1  1 = sources may start new messages
o_src  output  NUM_SRC*ASZ  per-source src field, channel k at [k*ASZ +: ASZ]
o_dst  output  NUM_SRC*ASZ  per-source dst field
o_dat  output  NUM_SRC*DSZ  per-source data field
o_red  output  NUM_SRC*RSZ  per-source redundancy field
o_req  output  NUM_SRC  per-source request
o_ack  input  NUM_SRC  per-source acknowledge
i0_src  input  ASZ  sink src field
i0_dst  input  ASZ  sink dst field
i0_dat  input  DSZ  sink data
i0_red  input  RSZ  sink redundancy
i0_req  input  1  sink request
i0_ack  output  1  sink acknowledge
o_seq_err  output  NUM_SRC  sticky per-source sequence error
o_src_err  output  1  sticky unknown-src error
o_red_err  output  1  sticky redundancy error
o_fst_err_vld  output  1  first-error capture valid
o_fst_err_src  output  ASZ  src of the first failing message
o_fst_err_exp  output  DSZ  expected data at the first error
o_fst_err_got  output  DSZ  received data at the first error
o_rx_total  output  16  messages accepted by the sink, saturating at 16'hFFFF
o_done  output  1  all sources finished and all their messages received

Behaviour:
- Reset (async assert, sync release) clears all state. All outputs are 0, except o_dst[k] = MIN_ADDR. o_req drops immediately on reset assertion.
- Source k runs four-phase handshake rules:
  - IDLE: if i_run, !o_req[k], !o_ack[k], and not finished, load dat = zero-extended seq_k and raise req next cycle.
  - WAIT_ACK: on o_ack[k]=1, drop req, advance seq_k = seq_k+1 mod 2^CSZ, and set dst = dst>=MAX_ADDR ? MIN_ADDR : dst+1.
  - A new req is not raised until ack returns low.
  - Fields stay stable while req=1.
- red = CHK_RED ? low RSZ bits of (src XOR dat) : 0.
- Sent counter per source. When MSG_CNT != 0 and sent == MSG_CNT, the source is finished and never re-arms. i_run deasserting mid-message does not drop req; it only blocks the next message.
- Sink:
  - On i0_req=1 and i0_ack=0: check the message, then set i0_ack=1 the next cycle (1-cycle latency).
  - On i0_req=0 and i0_ack=1: clear i0_ack.
  - One message is processed per handshake.
- Checks use idx = i0_src - SRC_BASE:
  - idx >= NUM_SRC (unsigned): set o_src_err; no sequence check.
  - Otherwise compare i0_dat with exp_idx (reset 0). On mismatch, set o_seq_err[idx] and resync exp_idx = i0_dat+1. On match, exp_idx = exp_idx+1. Both wrap mod 2^CSZ.
  - Any bit of i0_dat above CSZ set counts as a mismatch.
  - CHK_RED=1 and i0_red != low RSZ bits of (i0_src XOR i0_dat): set o_red_err.
- First error: the first check failure of any kind latches src, exp and got, and sets o_fst_err_vld. For a src error, exp = 0. Later errors never overwrite the capture.
- All error flags are sticky until reset.
- o_rx_total increments on each accepted message.
- o_done: MSG_CNT != 0, all sources finished, and o_rx_total == NUM_SRC*MSG_CNT (saturated compare). o_done stays 0 when MSG_CNT = 0.

Test Plan:
- NUM_SRC=2, MSG_CNT=20, DUT = fair merge → no errors, o_rx_total=40, o_done=1; each source's data wraps 15→0.
- NUM_SRC=4, MIN_ADDR=1, MAX_ADDR=3, loopback → dst sequence 1,2,3,1 per source; no errors.
- Inject out-of-order delivery (src 1 delivers dat 3 while exp=2) → o_seq_err=2'b10, fst_err = {src=1, exp=2, got=3}, vld=1; a later error leaves the capture unchanged.
- Inject i0_src = SRC_BASE+NUM_SRC → o_src_err=1 and the sink still acks. CHK_RED=1 with a corrupted red → o_red_err=1.
- Drop i_run mid-message → the pending req completes and no new req follows; reassert i_run → the sequence continues with no gap.
- Assert i_rst_n low while o_req=1 and i0_ack=1 → all req and ack outputs go 0 immediately; after release, dat restarts at 0 and dst at MIN_ADDR.
